// File: rtl/lsu_rmw_if.sv
// Bus between the core, the load/store unit and the word-wide data memory.
// Request side (mem_req .. wdata) is held stable by the core while stall is high.
// There is no valid/ready pair here: mem_req qualifies a request, and stall is
// the only back-pressure. A sub-word store completes on the edge where stall is low.
interface lsu_rmw_if;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic [31:0] dmem_a;
    logic        dmem_we;
    logic [31:0] dmem_wd;
    logic [31:0] dmem_rd;

    // Core plus memory model side.
    modport master (
        output mem_req, mem_we, funct3, addr, wdata, dmem_rd,
        input  rdata, stall, misaligned, dmem_a, dmem_we, dmem_wd
    );

    // Load/store unit side.
    modport slave (
        input  mem_req, mem_we, funct3, addr, wdata, dmem_rd,
        output rdata, stall, misaligned, dmem_a, dmem_we, dmem_wd
    );
endinterface

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-wide RAM without byte enables.
// Loads are extracted and extended combinationally; SW is a direct write;
// SB/SH are a read-modify-write: IDLE (stall) -> RMW_RD (stall, capture word)
// -> RMW_WR (write merged word, core advances).
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned half/word
// accesses instead of silently ignoring the low address bits.
module lsu_rmw #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    lsu_rmw_if.slave    bus,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [XLEN-1:0]  rd_q;
    logic             is_load;
    logic             is_store;
    logic             mis;
    logic             we_raw;
    logic [31:0]      merged;
    logic [31:0]      load_val;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;

    assign is_load   = bus.mem_req & ~bus.mem_we;
    assign is_store  = bus.mem_req & bus.mem_we;
    assign bus.dmem_a = {bus.addr[31:2], 2'b00};
    assign state_dbg  = state;

    // Misalignment detection: only active when the trap feature is built in.
`ifdef MISALIGN_TRAP_EN
    always_comb begin
        mis = 1'b0;
        if (bus.mem_req) begin
            if ((bus.funct3 == 3'b001 || (is_load && bus.funct3 == 3'b101)) && bus.addr[0])
                mis = 1'b1;
            if (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00)
                mis = 1'b1;
        end
    end
`else
    assign mis = 1'b0;
`endif
    assign bus.misaligned = mis;

    // FSM state register and captured RAM word for the merge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rd_q  <= '0;
        end else begin
            state <= state_next;
            if (state == RMW_RD)
                rd_q <= bus.dmem_rd;
        end
    end

    // Next state, stall and write strobe.
    always_comb begin
        state_next  = state;
        bus.stall   = 1'b0;
        we_raw      = 1'b0;
        bus.dmem_wd = bus.wdata;
        case (state)
            IDLE: begin
                if (is_store && !mis) begin
                    case (bus.funct3)
                        3'b010: we_raw = 1'b1;
                        3'b000, 3'b001: begin
                            bus.stall  = 1'b1;
                            state_next = RMW_RD;
                        end
                        default: ;
                    endcase
                end
            end
            RMW_RD: begin
                bus.stall  = 1'b1;
                state_next = RMW_WR;
            end
            RMW_WR: begin
                we_raw      = 1'b1;
                bus.dmem_wd = merged;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A write must never escape while reset is held, even with a store pending.
    assign bus.dmem_we = we_raw & ~reset;

    // Merge the store lane into the captured word (funct3[0]: 0 byte, 1 half).
    always_comb begin
        merged = rd_q;
        if (!bus.funct3[0]) begin
            case (bus.addr[1:0])
                2'd0: merged[7:0]   = bus.wdata[7:0];
                2'd1: merged[15:8]  = bus.wdata[7:0];
                2'd2: merged[23:16] = bus.wdata[7:0];
                default: merged[31:24] = bus.wdata[7:0];
            endcase
        end else if (bus.addr[1]) begin
            merged[31:16] = bus.wdata[15:0];
        end else begin
            merged[15:0] = bus.wdata[15:0];
        end
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        load_val = '0;
        case (bus.addr[1:0])
            2'd0: byte_lane = bus.dmem_rd[7:0];
            2'd1: byte_lane = bus.dmem_rd[15:8];
            2'd2: byte_lane = bus.dmem_rd[23:16];
            default: byte_lane = bus.dmem_rd[31:24];
        endcase
        half_lane = bus.addr[1] ? bus.dmem_rd[31:16] : bus.dmem_rd[15:0];
        if (state == IDLE && is_load && !mis) begin
            case (bus.funct3)
                3'b000: load_val = {{24{byte_lane[7]}}, byte_lane};
                3'b001: load_val = {{16{half_lane[15]}}, half_lane};
                3'b010: load_val = bus.dmem_rd;
                3'b100: load_val = {24'd0, byte_lane};
                3'b101: load_val = {16'd0, half_lane};
                default: load_val = '0;
            endcase
        end
    end
    assign bus.rdata = load_val;

endmodule
